temperature_serial_tx: RTL and testbench

Serial transmitter for 16-bit temperature readings: accepts a parallel value on a valid/ready handshake and serialises it MSB-first on `sda`, with a self-generated `scl` derived from `clk`. It is the sending end of the temperature link. The receiver samples `sda` on each rising `scl` and counts `TEMPERATURE_WIDTH` rises per reading. The block serves as the sensor-side serialiser in the design and as the stimulus source for receiver benches.

---
 rtl/temperature_pkg.sv | 19 +
 rtl/temperature_serial_tx_half_period_timer.sv | 26 ++
 rtl/temperature_serial_tx.sv | 129 ++++++++++++
 tb/tb_temperature_serial_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/temperature_pkg.sv
// Shared constants and state encoding for the temperature serial link.
package temperature_pkg;

  localparam int TEMPERATURE_WIDTH       = 16;
  localparam int DEFAULT_SCL_HALF_PERIOD = 50;
  localparam int DEFAULT_GAP_CYCLES      = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    GAP
  } tx_state_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/temperature_serial_tx_half_period_timer.sv
// Loadable down-counter; terminalCount is high while the count sits at zero.
module half_period_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             terminalCount
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign terminalCount = (count == '0);

endmodule

// File: rtl/temperature_serial_tx.sv
// MSB-first serialiser for temperature readings with a self-generated scl.
// Optional inter-frame gap enabled by defining TEMPERATURE_TX_GAP_EN.
module temperature_serial_tx #(
  parameter int TEMPERATURE_WIDTH = temperature_pkg::TEMPERATURE_WIDTH,
  parameter int SCL_HALF_PERIOD   = temperature_pkg::DEFAULT_SCL_HALF_PERIOD,
  parameter int GAP_CYCLES        = temperature_pkg::DEFAULT_GAP_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [TEMPERATURE_WIDTH-1:0] temperature,
  input  logic                         temperatureValid,
  output logic                         temperatureReady,
  output logic                         scl,
  output logic                         sda,
  output logic                         busy,
  output logic                         frameDone
);
  import temperature_pkg::*;

  // Timer is shared between half periods and the gap, so size it for both.
  localparam int TIMER_W = $clog2(maxInt(SCL_HALF_PERIOD, GAP_CYCLES) + 1);
  localparam int BIT_W   = $clog2(TEMPERATURE_WIDTH);
  localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(SCL_HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(TEMPERATURE_WIDTH - 1);

  tx_state_t                    state, stateNext;
  logic [TEMPERATURE_WIDTH-1:0] shiftReg, shiftNext;
  logic [BIT_W-1:0]             bitIdx, bitNext;
  logic                         sclNext, sdaNext, doneNext;
  logic                         timerLoad, timerTc;
  logic [TIMER_W-1:0]           timerValue;

  half_period_timer #(.WIDTH(TIMER_W)) uTimer (
    .clk           (clk),
    .reset         (reset),
    .load          (timerLoad),
    .loadValue     (timerValue),
    .terminalCount (timerTc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      shiftReg         <= '0;
      bitIdx           <= '0;
      scl              <= 1'b0;
      sda              <= 1'b0;
      frameDone        <= 1'b0;
      temperatureReady <= 1'b1;
      busy             <= 1'b0;
    end else begin
      state            <= stateNext;
      shiftReg         <= shiftNext;
      bitIdx           <= bitNext;
      scl              <= sclNext;
      sda              <= sdaNext;
      frameDone        <= doneNext;
      temperatureReady <= (stateNext == IDLE);
      busy             <= (stateNext != IDLE);
    end
  end

  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitNext    = bitIdx;
    timerLoad  = 1'b0;
    timerValue = HALF_LOAD;
    sclNext    = 1'b0;
    sdaNext    = sda;
    doneNext   = 1'b0;
    case (state)
      IDLE: begin
        sdaNext = 1'b0;
        if (temperatureValid && temperatureReady) begin
          shiftNext = temperature;
          bitNext   = BIT_LAST;
          sdaNext   = temperature[TEMPERATURE_WIDTH-1];
          timerLoad = 1'b1;
          stateNext = LOW;
        end
      end
      LOW: begin
        if (timerTc) begin
          sclNext   = 1'b1;
          timerLoad = 1'b1;
          stateNext = HIGH;
        end
      end
      HIGH: begin
        sclNext = 1'b1;
        if (timerTc) begin
          sclNext = 1'b0;
          if (bitIdx == '0) begin
            sdaNext  = 1'b0;
            doneNext = 1'b1;
`ifdef TEMPERATURE_TX_GAP_EN
            timerLoad  = 1'b1;
            timerValue = TIMER_W'(GAP_CYCLES - 1);
            stateNext  = GAP;
`else
            stateNext = IDLE;
`endif
          end else begin
            // Next bit goes out on the same edge that drops scl.
            shiftNext = {shiftReg[TEMPERATURE_WIDTH-2:0], 1'b0};
            sdaNext   = shiftReg[TEMPERATURE_WIDTH-2];
            bitNext   = bitIdx - 1'b1;
            timerLoad = 1'b1;
            stateNext = LOW;
          end
        end
      end
`ifdef TEMPERATURE_TX_GAP_EN
      GAP: begin
        sdaNext = 1'b0;
        if (timerTc) begin
          stateNext = IDLE;
        end
      end
`endif
      default: begin
        sdaNext   = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_temperature_serial_tx.sv
// Scoreboard bench: two DUTs (half period 4 and 1) with a loop-back receiver monitor.
module tb_temperature_serial_tx;

`ifdef TEMPERATURE_TX_GAP_EN
  localparam int EXP_GAP = 10;
`else
  localparam int EXP_GAP = 0;
`endif

  typedef struct {
    logic [15:0] value;
    int          latency;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rstN, valid, ready, scl, sda, busy, done;
  logic [15:0] temp [2];

  exp_t expQ0[$];
  exp_t expQ1[$];

  int errors = 0;
  int checks = 0;

  int          riseCnt [2];
  int          cyc     [2];
  int          gapCnt  [2];
  logic [15:0] shiftR  [2];
  bit          inFrame [2];
  bit          readyBad[2];
  bit          gapActive[2];
  bit          gapScl  [2];
  bit          prevScl [2];

  always #5 clk = ~clk;

  temperature_serial_tx #(.TEMPERATURE_WIDTH(16), .SCL_HALF_PERIOD(4), .GAP_CYCLES(10)) dut0 (
    .clk(clk), .reset(rstN[0]), .temperature(temp[0]), .temperatureValid(valid[0]),
    .temperatureReady(ready[0]), .scl(scl[0]), .sda(sda[0]), .busy(busy[0]), .frameDone(done[0])
  );

  temperature_serial_tx #(.TEMPERATURE_WIDTH(16), .SCL_HALF_PERIOD(1), .GAP_CYCLES(10)) dut1 (
    .clk(clk), .reset(rstN[1]), .temperature(temp[1]), .temperatureValid(valid[1]),
    .temperatureReady(ready[1]), .scl(scl[1]), .sda(sda[1]), .busy(busy[1]), .frameDone(done[1])
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Loop-back receiver and scoreboard: samples on negedge, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstN[d]) begin
        riseCnt[d]   = 0;
        inFrame[d]   = 0;
        prevScl[d]   = 0;
        gapActive[d] = 0;
      end else begin
        exp_t e;
        if (inFrame[d]) cyc[d]++;
        if (scl[d] && !prevScl[d]) begin
          riseCnt[d]++;
          shiftR[d] = {shiftR[d][14:0], sda[d]};
        end
        if (gapActive[d] && scl[d]) gapScl[d] = 1;
        prevScl[d] = scl[d];
        if (inFrame[d] && !done[d] && (ready[d] || !busy[d])) readyBad[d] = 1;

        if (done[d]) begin
          chk($sformatf("dut%0d frameDone inside frame", d), inFrame[d], 1);
          if ((d == 0 && expQ0.size() == 0) || (d == 1 && expQ1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected frame: got %0h expected none", d, shiftR[d]);
          end else begin
            e = (d == 0) ? expQ0.pop_front() : expQ1.pop_front();
            chk($sformatf("dut%0d decoded value", d), shiftR[d], e.value);
            chk($sformatf("dut%0d scl rises", d), riseCnt[d], 16);
            chk($sformatf("dut%0d frameDone latency", d), cyc[d], e.latency);
            chk($sformatf("dut%0d ready/busy during frame", d), readyBad[d], 0);
          end
          inFrame[d]   = 0;
          riseCnt[d]   = 0;
          gapActive[d] = 1;
          gapCnt[d]    = 0;
          gapScl[d]    = 0;
        end

        if (gapActive[d]) begin
          if (ready[d]) begin
            chk($sformatf("dut%0d gap length", d), gapCnt[d], EXP_GAP);
            chk($sformatf("dut%0d scl quiet in gap", d), gapScl[d], 0);
            gapActive[d] = 0;
          end else begin
            gapCnt[d]++;
          end
        end

        if (valid[d] && ready[d] && !inFrame[d]) begin
          inFrame[d]  = 1;
          cyc[d]      = 0;
          readyBad[d] = 0;
        end
      end
    end
  end

  task automatic send(input int d, input logic [15:0] v, input bit corrupt, input bit keepValid);
    @(posedge clk); #1;
    temp[d]  = v;
    valid[d] = 1'b1;
    for (int n = 0; n < 500 && !ready[d]; n++) begin
      @(posedge clk); #1;
    end
    chk($sformatf("dut%0d accept before timeout", d), ready[d], 1);
    @(posedge clk); #1;
    if (corrupt) temp[d] = 16'hFFFF;
    if (!keepValid) valid[d] = 1'b0;
  endtask

  task automatic waitReady(input int d);
    for (int n = 0; n < 600 && !ready[d]; n++) begin
      @(posedge clk); #1;
    end
    chk($sformatf("dut%0d ready after frame", d), ready[d], 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rstN    = 2'b00;
    valid   = 2'b00;
    temp[0] = '0;
    temp[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d reset ready", d), ready[d], 1);
      chk($sformatf("dut%0d reset busy", d), busy[d], 0);
      chk($sformatf("dut%0d reset scl", d), scl[d], 0);
      chk($sformatf("dut%0d reset sda", d), sda[d], 0);
      chk($sformatf("dut%0d reset frameDone", d), done[d], 0);
    end
    rstN = 2'b11;

    // Single frame, 0xA5C3: bits 1010010111000011, done at accept + 2*16*4 + 1.
    expQ0.push_back('{16'hA5C3, 129});
    send(0, 16'hA5C3, 0, 0);
    waitReady(0);

    // Back-to-back with valid held high.
    expQ0.push_back('{16'h0001, 129});
    expQ0.push_back('{16'hFFFF, 129});
    send(0, 16'h0001, 0, 1);
    send(0, 16'hFFFF, 0, 0);
    waitReady(0);

    // Input corrupted one cycle after accept must not reach the line.
    expQ0.push_back('{16'h1234, 129});
    send(0, 16'h1234, 1, 0);
    waitReady(0);

    // Abandon a frame after five rises; outputs must clear without a clock edge.
    send(0, 16'h5555, 0, 0);
    for (int n = 0; n < 200 && !(riseCnt[0] == 5 && scl[0]); n++) begin
      @(posedge clk); #1;
    end
    chk("dut0 reached five rises", riseCnt[0], 5);
    #2;
    rstN[0] = 1'b0;
    #1;
    chk("dut0 async reset scl", scl[0], 0);
    chk("dut0 async reset sda", sda[0], 0);
    chk("dut0 async reset ready", ready[0], 1);
    chk("dut0 async reset busy", busy[0], 0);
    repeat (2) @(posedge clk);
    #1;
    rstN[0] = 1'b1;
    @(posedge clk); #1;
    chk("dut0 ready after reset release", ready[0], 1);
    expQ0.push_back('{16'h00FF, 129});
    send(0, 16'h00FF, 0, 0);
    waitReady(0);

    // Half period of one: done at accept + 2*16*1 + 1.
    expQ1.push_back('{16'h8000, 33});
    send(1, 16'h8000, 0, 0);
    waitReady(1);

    repeat (20) @(posedge clk);
    #1;
    chk("dut0 scoreboard drained", expQ0.size(), 0);
    chk("dut1 scoreboard drained", expQ1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
